res_ram_arbiter: RTL and testbench

- Shares the four single-port res_ram banks between N_REQ requesters: conv engine writes results, dense engine reads activations, host reads/writes over Avalon.
- One shared address drives all four banks. Each access moves one 32-bit word: byte k maps to bank k and has its own write enable.
- Round-robin arbitration with a bounded burst hold. Read data is routed back to the issuing requester after the fixed RAM latency.
- Sits between the compute engines and the memory block's res_ram port.

---
 rtl/res_ram_arbiter_pkg.sv | 15 +
 rtl/res_ram_arbiter_rr_pick.sv | 32 +++
 rtl/res_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_res_ram_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/res_ram_arbiter_pkg.sv
// Shared types and constants for the res_ram arbiter and its requesters.
package res_arb_pkg;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned ADDR_W = 16;

  typedef logic [$clog2(N_REQ)-1:0] req_id_t;

  localparam req_id_t REQ_CONV  = req_id_t'(0);
  localparam req_id_t REQ_DENSE = req_id_t'(1);
  localparam req_id_t REQ_HOST  = req_id_t'(2);

  typedef logic [31:0] res_word_t;

endpackage

// File: rtl/res_ram_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning from i_ptr upward,
// wrapping modulo N.
module rr_pick
  import res_arb_pkg::*;
#(
  parameter int unsigned N    = res_arb_pkg::N_REQ,
  parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_onehot,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  always_comb begin
    o_onehot = '0;
    o_id     = '0;
    o_any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_req[idx]) begin
        o_any         = 1'b1;
        o_onehot[idx] = 1'b1;
        o_id          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/res_ram_arbiter.sv
// Shares the four byte-wide res_ram banks between conv, dense and host with
// round-robin arbitration, bounded burst hold and routed read returns.
module res_ram_arbiter
  import res_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = res_arb_pkg::N_REQ,
  parameter int unsigned ADDR_W    = res_arb_pkg::ADDR_W,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][31:0]        wdata,
  input  logic [N_REQ-1:0][3:0]         be,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output res_word_t                     rdata,
  output logic [ADDR_W-1:0]             res_ram_addr,
  output logic [7:0]                    res_ram_data0,
  output logic [7:0]                    res_ram_data1,
  output logic [7:0]                    res_ram_data2,
  output logic [7:0]                    res_ram_data3,
  output logic                          we_res0,
  output logic                          we_res1,
  output logic                          we_res2,
  output logic                          we_res3,
  input  logic [7:0]                    read_res0,
  input  logic [7:0]                    read_res1,
  input  logic [7:0]                    read_res2,
  input  logic [7:0]                    read_res3
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

  logic [ID_W-1:0]              r_ptr;
  logic [ID_W-1:0]              r_owner;
  logic                         r_owner_valid;
  logic [BC_W-1:0]              r_bcnt;
  logic [RD_LAT-1:0]            r_pv;
  logic [RD_LAT-1:0][ID_W-1:0]  r_pid;

  logic [N_REQ-1:0] w_rr_onehot;
  logic [ID_W-1:0]  w_rr_id;
  logic             w_rr_any;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_others;
  logic             w_hold;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gid;
  logic             w_any;
  logic             w_wr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic [N_REQ-1:0] w_rv;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_rr_onehot),
    .o_id     (w_rr_id),
    .o_any    (w_rr_any)
  );

  // Owner keeps the bank while under its burst budget, or indefinitely when
  // nobody else is asking; otherwise the round-robin pick takes over.
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
    w_others            = |(req & ~w_owner_oh);
    w_hold              = r_owner_valid && req[r_owner] &&
                          ((r_bcnt < BC_W'(MAX_BURST)) || !w_others);
    w_gnt = '0;
    w_gid = r_owner;
    w_any = 1'b0;
    if (!reset) begin
      if (w_hold) begin
        w_gnt = w_owner_oh;
        w_any = 1'b1;
      end else if (w_rr_any) begin
        w_gnt = w_rr_onehot;
        w_gid = w_rr_id;
        w_any = 1'b1;
      end
    end
  end

  assign gnt = w_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_bcnt        <= '0;
    end else if (!w_any) begin
      r_owner_valid <= 1'b0;
    end else if (r_owner_valid && (w_gid == r_owner)) begin
      r_bcnt <= (r_bcnt >= BC_W'(MAX_BURST)) ? BC_W'(1) : r_bcnt + BC_W'(1);
    end else begin
      r_bcnt        <= BC_W'(1);
      r_owner       <= w_gid;
      r_owner_valid <= 1'b1;
      r_ptr         <= (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv  <= '0;
      r_pid <= '0;
    end else begin
      r_pv[0]  <= w_any && !we[w_gid];
      r_pid[0] <= w_gid;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
    end
  end

  always_comb begin
    w_wr         = w_any && we[w_gid];
    res_ram_addr = w_any ? addr[w_gid] : '0;
    w_wdata      = w_wr ? wdata[w_gid] : '0;
    w_be         = w_wr ? be[w_gid] : '0;
  end

  assign res_ram_data0 = w_wdata[7:0];
  assign res_ram_data1 = w_wdata[15:8];
  assign res_ram_data2 = w_wdata[23:16];
  assign res_ram_data3 = w_wdata[31:24];
  assign we_res0       = w_be[0];
  assign we_res1       = w_be[1];
  assign we_res2       = w_be[2];
  assign we_res3       = w_be[3];

  // Reset masks the return stage combinationally so a read issued just before
  // reset never surfaces.
  always_comb begin
    w_rv = '0;
    if (!reset && r_pv[RD_LAT-1]) w_rv[r_pid[RD_LAT-1]] = 1'b1;
    rdata = (|w_rv) ? {read_res3, read_res2, read_res1, read_res0} : '0;
  end

  assign rvalid = w_rv;

  a_invariants: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt) && ((gnt & ~req) == '0) && $onehot0(rvalid));

  for (genvar i = 0; i < N_REQ; i++) begin : g_obl
    a_stable: assert property (@(posedge clk) disable iff (reset)
      (req[i] && $past(!reset && req[i] && !gnt[i])) |->
      (we[i] == $past(we[i]) && addr[i] == $past(addr[i]) &&
       wdata[i] == $past(wdata[i]) && be[i] == $past(be[i])));
  end

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Directed bench for res_ram_arbiter with a behavioural four-bank res_ram.
module tb_res_ram_arbiter;
  import res_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [2:0]        req, we, gnt, rvalid;
  logic [2:0][15:0]  addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][3:0]   be;
  logic [31:0]       rdata;
  logic [15:0]       res_ram_addr;
  logic [7:0]        d0, d1, d2, d3, q0, q1, q2, q3;
  logic              w0, w1, w2, w3;

  res_ram_arbiter #(.N_REQ(3), .ADDR_W(16), .MAX_BURST(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .res_ram_addr(res_ram_addr),
    .res_ram_data0(d0), .res_ram_data1(d1), .res_ram_data2(d2), .res_ram_data3(d3),
    .we_res0(w0), .we_res1(w1), .we_res2(w2), .we_res3(w3),
    .read_res0(q0), .read_res1(q1), .read_res2(q2), .read_res3(q3)
  );

  // Banks: registered address, unregistered q.
  logic [7:0]  mem [4][65536];
  logic [15:0] ram_raddr = '0;
  always @(posedge clk) begin
    if (w0) mem[0][res_ram_addr] <= d0;
    if (w1) mem[1][res_ram_addr] <= d1;
    if (w2) mem[2][res_ram_addr] <= d2;
    if (w3) mem[3][res_ram_addr] <= d3;
    ram_raddr <= res_ram_addr;
  end
  assign q0 = mem[0][ram_raddr];
  assign q1 = mem[1][ram_raddr];
  assign q2 = mem[2][ram_raddr];
  assign q3 = mem[3][ram_raddr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] w);
    mem[0][a] = w[7:0];
    mem[1][a] = w[15:8];
    mem[2][a] = w[23:16];
    mem[3][a] = w[31:24];
  endtask

  // Non-requesting ports carry decoy values so a wrong mux select is visible.
  task automatic drive(input logic rst, input logic [2:0] r, input logic [2:0] w,
                       input logic [15:0] a, input logic [31:0] wd, input logic [3:0] b);
    reset = rst;
    req   = r;
    we    = w;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = r[i] ? a  : 16'hBEEF;
      wdata[i] = r[i] ? wd : 32'hDEADBEEF;
      be[i]    = r[i] ? b  : 4'hF;
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [2:0]  egnt;
    logic [2:0]  erv;
    logic [31:0] erd;
    logic [15:0] eaddr;
    logic [3:0]  ewe;
    logic [31:0] edat;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  initial begin
    int conv_cnt;
    logic found;
    logic [2:0] prev_gnt;

    drive(1'b1, 3'b000, 3'b000, 16'h0, 32'h0, 4'h0);
    preload(16'h0010, 32'hA1B2C3D4);
    preload(16'h0004, 32'h01020304);
    preload(16'h0008, 32'h05060708);
    preload(16'h0123, 32'hAABBCCDD);

    //        rst req     we      a        wd            be       gnt     rv      rdata         addr     we_res   data
    v[0]  = '{1'b1, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b000, 32'h0,        16'h0000, 4'b0000, 32'h0};
    v[1]  = '{1'b1, 3'b111, 3'b000, 16'h0010, 32'h0,        4'b0000, 3'b000, 3'b000, 32'h0,        16'h0000, 4'b0000, 32'h0};
    v[2]  = '{1'b0, 3'b010, 3'b000, 16'h0010, 32'h0,        4'b0000, 3'b010, 3'b000, 32'h0,        16'h0010, 4'b0000, 32'h0};
    v[3]  = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b010, 32'hA1B2C3D4, 16'h0000, 4'b0000, 32'h0};
    v[4]  = '{1'b0, 3'b100, 3'b100, 16'h0123, 32'h11223344, 4'b0101, 3'b100, 3'b000, 32'h0,        16'h0123, 4'b0101, 32'h11223344};
    v[5]  = '{1'b0, 3'b100, 3'b000, 16'h0123, 32'h0,        4'b0000, 3'b100, 3'b000, 32'h0,        16'h0123, 4'b0000, 32'h0};
    v[6]  = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b100, 32'hAA22CC44, 16'h0000, 4'b0000, 32'h0};
    v[7]  = '{1'b0, 3'b010, 3'b000, 16'h0004, 32'h0,        4'b0000, 3'b010, 3'b000, 32'h0,        16'h0004, 4'b0000, 32'h0};
    v[8]  = '{1'b0, 3'b100, 3'b000, 16'h0008, 32'h0,        4'b0000, 3'b100, 3'b010, 32'h01020304, 16'h0008, 4'b0000, 32'h0};
    v[9]  = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b100, 32'h05060708, 16'h0000, 4'b0000, 32'h0};
    v[10] = '{1'b0, 3'b001, 3'b001, 16'h0004, 32'hCAFEF00D, 4'b1111, 3'b001, 3'b000, 32'h0,        16'h0004, 4'b1111, 32'hCAFEF00D};
    v[11] = '{1'b0, 3'b010, 3'b000, 16'h0004, 32'h0,        4'b0000, 3'b010, 3'b000, 32'h0,        16'h0004, 4'b0000, 32'h0};
    v[12] = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b010, 32'hCAFEF00D, 16'h0000, 4'b0000, 32'h0};
    v[13] = '{1'b0, 3'b001, 3'b001, 16'h0008, 32'hFFFFFFFF, 4'b0000, 3'b001, 3'b000, 32'h0,        16'h0008, 4'b0000, 32'hFFFFFFFF};
    v[14] = '{1'b0, 3'b001, 3'b000, 16'h0008, 32'h0,        4'b0000, 3'b001, 3'b000, 32'h0,        16'h0008, 4'b0000, 32'h0};
    v[15] = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b001, 32'h05060708, 16'h0000, 4'b0000, 32'h0};
    v[16] = '{1'b0, 3'b010, 3'b000, 16'h0010, 32'h0,        4'b0000, 3'b010, 3'b000, 32'h0,        16'h0010, 4'b0000, 32'h0};
    v[17] = '{1'b1, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b000, 32'h0,        16'h0000, 4'b0000, 32'h0};
    v[18] = '{1'b0, 3'b111, 3'b000, 16'h0010, 32'h0,        4'b0000, 3'b001, 3'b000, 32'h0,        16'h0010, 4'b0000, 32'h0};
    v[19] = '{1'b0, 3'b000, 3'b000, 16'h0000, 32'h0,        4'b0000, 3'b000, 3'b001, 32'hA1B2C3D4, 16'h0000, 4'b0000, 32'h0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(v[i].rst, v[i].req, v[i].we, v[i].a, v[i].wd, v[i].be);
      #1;
      chk($sformatf("v%0d_gnt", i),    32'(gnt),          32'(v[i].egnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid),       32'(v[i].erv));
      chk($sformatf("v%0d_rdata", i),  rdata,             v[i].erd);
      chk($sformatf("v%0d_addr", i),   32'(res_ram_addr), 32'(v[i].eaddr));
      chk($sformatf("v%0d_we_res", i), 32'({w3, w2, w1, w0}), 32'(v[i].ewe));
      chk($sformatf("v%0d_data", i),   {d3, d2, d1, d0},  v[i].edat);
    end

    // Fairness: all three reading continuously after reset.
    @(negedge clk);
    drive(1'b1, 3'b000, 3'b000, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b111;
    we    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 16'h0100 + 16'(i);
      wdata[i] = 32'h0;
      be[i]    = 4'h0;
    end
    prev_gnt = 3'b000;
    for (int c = 0; c < 48; c++) begin
      logic [2:0] eg;
      if (c > 0) @(negedge clk);
      #1;
      eg = 3'b001 << ((c / 8) % 3);
      chk($sformatf("rr_gnt_c%0d", c),    32'(gnt),    32'(eg));
      chk($sformatf("rr_rvalid_c%0d", c), 32'(rvalid), 32'(prev_gnt));
      prev_gnt = eg;
    end

    // Burst extension: conv alone for 20 cycles, then dense joins.
    @(negedge clk);
    drive(1'b1, 3'b000, 3'b000, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b001;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("burst_gnt_c%0d", c), 32'(gnt), 32'h1);
    end
    @(negedge clk);
    req = 3'b011;
    conv_cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (gnt == 3'b010) found = 1'b1;
      else if (gnt == 3'b001) conv_cnt++;
    end
    chk("burst_dense_granted", 32'(found), 32'h1);
    chk("burst_conv_extra", 32'(conv_cnt), 32'd4);

    @(negedge clk);
    drive(1'b0, 3'b000, 3'b000, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
